// File: rtl/biquad8_pkg.sv
// Shared types and register-map constants for the biquad coefficient loader.
package biquad8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam int unsigned WORD_ADR_W = 5;
  localparam int unsigned COEFF_W    = 18;
  localparam int unsigned ENTRY_W    = WORD_ADR_W + COEFF_W;
  localparam int unsigned BUS_ADR_W  = 7;
  localparam int unsigned BUS_DAT_W  = 32;
  localparam int unsigned BUS_SEL_W  = 4;

  localparam logic [BUS_ADR_W-1:0] ADR_UPDATE    = 7'h00;
  localparam logic [BUS_ADR_W-1:0] ADR_FIR       = 7'h04;
  localparam logic [BUS_ADR_W-1:0] ADR_POLE_BASE = 7'h10;

  typedef struct packed {
    logic [WORD_ADR_W-1:0] word_adr;
    logic [COEFF_W-1:0]    coeff;
  } coeff_entry_t;

  // Register words are 32-bit, so the byte address is the word index times four.
  function automatic logic [BUS_ADR_W-1:0] word_to_byte_adr(input logic [WORD_ADR_W-1:0] word_adr);
    return {word_adr, 2'b00};
  endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// WISHBONE classic master/slave bundle between the loader and the biquad register space.
interface biquad8_coeff_loader_if;

  logic                                 wbm_cyc_o;
  logic                                 wbm_stb_o;
  logic                                 wbm_we_o;
  logic [biquad8_pkg::BUS_ADR_W-1:0]    wbm_adr_o;
  logic [biquad8_pkg::BUS_DAT_W-1:0]    wbm_dat_o;
  logic [biquad8_pkg::BUS_SEL_W-1:0]    wbm_sel_o;
  logic                                 wbm_ack_i;
  logic                                 wbm_err_i;
  logic                                 wbm_rty_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i
  );

endinterface

// File: rtl/biquad8_coeff_table.sv
// Simple dual-port coefficient table: one write port, one synchronous read port.
module biquad8_coeff_table #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_adr,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_adr,
  output logic [WIDTH-1:0]         rd_dat
);

  // Deliberately unreset so contents survive a loader reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_adr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_dat <= mem[rd_adr];
    end
  end

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Streams a coefficient table into the biquad register space over WISHBONE,
// then writes the update register to commit the new coefficients.
module biquad8_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     cfg_wr_i,
  input  logic [$clog2(DEPTH)-1:0] cfg_adr_i,
  input  logic [ENTRY_W-1:0]       cfg_dat_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  biquad8_coeff_loader_if.master   wbm
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t                 state, state_nxt;
  logic [LW-1:0]          index, index_nxt, index_inc;
  logic [LW-1:0]          len_q, len_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   cyc, cyc_nxt;
  logic                   err, err_nxt;
  logic                   busy, done;
  logic                   abort;
  logic [BUS_ADR_W-1:0]   adr, adr_nxt;
  logic [BUS_DAT_W-1:0]   dat, dat_nxt;
  coeff_entry_t           rd_entry;
  logic                   rd_en;
  logic [AW-1:0]          rd_adr;

  // Entry is read on the edge into FETCH so it is valid while in FETCH.
  assign rd_en     = (state_nxt == ST_FETCH);
  assign rd_adr    = index_nxt[AW-1:0];
  assign index_inc = index + LW'(1);

  biquad8_coeff_table #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_table (
    .clk    (wb_clk_i),
    .wr_en  (cfg_wr_i && (state == ST_IDLE)),
    .wr_adr (cfg_adr_i),
    .wr_dat (cfg_dat_i),
    .rd_en  (rd_en),
    .rd_adr (rd_adr),
    .rd_dat (rd_entry)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    len_nxt   = len_q;
    cnt_nxt   = cnt;
    cyc_nxt   = 1'b0;
    adr_nxt   = adr;
    dat_nxt   = dat;
    err_nxt   = err;
    abort     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          err_nxt = 1'b0;
          if (len_i != '0) begin
            len_nxt   = len_i;
            index_nxt = '0;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_UPDATE;
            adr_nxt   = ADR_UPDATE;
            dat_nxt   = BUS_DAT_W'(1);
            cnt_nxt   = '0;
            cyc_nxt   = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        state_nxt = ST_WRITE;
        adr_nxt   = word_to_byte_adr(rd_entry.word_adr);
        dat_nxt   = BUS_DAT_W'(rd_entry.coeff);
        cnt_nxt   = '0;
        cyc_nxt   = 1'b1;
      end

      ST_WRITE, ST_UPDATE: begin
        // cyc is low only for the idle cycle between the last entry and UPDATE.
        if (!cyc) begin
          cyc_nxt = 1'b1;
          cnt_nxt = '0;
        end else if (wbm.wbm_err_i || wbm.wbm_rty_i) begin
          abort = 1'b1;
        end else if (wbm.wbm_ack_i) begin
          if (state == ST_UPDATE) begin
            state_nxt = ST_DONE;
          end else begin
            index_nxt = index_inc;
            if (index_inc == len_q) begin
              state_nxt = ST_UPDATE;
              adr_nxt   = ADR_UPDATE;
              dat_nxt   = BUS_DAT_W'(1);
            end else begin
              state_nxt = ST_FETCH;
            end
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
          cyc_nxt = 1'b1;
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase

    if (abort) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      index <= '0;
      len_q <= '0;
      cnt   <= '0;
      cyc   <= 1'b0;
      adr   <= '0;
      dat   <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      len_q <= len_nxt;
      cnt   <= cnt_nxt;
      cyc   <= cyc_nxt;
      adr   <= adr_nxt;
      dat   <= dat_nxt;
      err   <= err_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= (state_nxt == ST_DONE);
    end
  end

  assign busy_o        = busy;
  assign done_o        = done;
  assign err_o         = err;
  assign wbm.wbm_cyc_o = cyc;
  assign wbm.wbm_stb_o = cyc;
  assign wbm.wbm_we_o  = cyc;
  assign wbm.wbm_sel_o = {BUS_SEL_W{cyc}};
  assign wbm.wbm_adr_o = adr;
  assign wbm.wbm_dat_o = dat;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader with a configurable WISHBONE slave model.
module tb_biquad8_coeff_loader;
  import biquad8_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cfg_wr_i;
  logic [4:0]  cfg_adr_i;
  logic [22:0] cfg_dat_i;
  logic [5:0]  len_i;
  logic        start_i;
  logic        busy_o, done_o, err_o;

  biquad8_coeff_loader_if bus ();

  biquad8_coeff_loader #(.DEPTH(32), .TIMEOUT(255)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cfg_wr_i  (cfg_wr_i),
    .cfg_adr_i (cfg_adr_i),
    .cfg_dat_i (cfg_dat_i),
    .len_i     (len_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .wbm       (bus.master)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model knobs
  int   ack_dly      = 0;
  int   err_at       = -1;
  bit   no_ack       = 1'b0;
  bit   comb_ack     = 1'b0;
  bit   ack_with_err = 1'b0;
  int   wr_seen      = 0;
  int   wait_cnt     = 0;
  logic ack_r        = 1'b0;
  logic err_r        = 1'b0;
  int   bad_bus      = 0;

  logic [6:0]  log_adr [$];
  logic [31:0] log_dat [$];

  logic [6:0]  exp_adr [4];
  logic [31:0] exp_dat [4];

  assign bus.wbm_ack_i = comb_ack ? (bus.wbm_cyc_o & bus.wbm_stb_o) : ack_r;
  assign bus.wbm_err_i = err_r;
  assign bus.wbm_rty_i = 1'b0;

  always @(posedge wb_clk_i) begin
    if (bus.wbm_cyc_o && bus.wbm_stb_o && !ack_r && !err_r && !comb_ack) begin
      if (wait_cnt >= ack_dly) begin
        wait_cnt <= 0;
        if (wr_seen == err_at) begin
          err_r   <= 1'b1;
          ack_r   <= ack_with_err;
          wr_seen <= wr_seen + 1;
        end else if (!no_ack) begin
          ack_r   <= 1'b1;
          wr_seen <= wr_seen + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
    end
  end

  // Record every successfully terminated write.
  always @(posedge wb_clk_i) begin
    if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i && !bus.wbm_err_i && !bus.wbm_rty_i) begin
      log_adr.push_back(bus.wbm_adr_o);
      log_dat.push_back(bus.wbm_dat_o);
      if (bus.wbm_sel_o !== 4'hF || bus.wbm_we_o !== 1'b1) bad_bus++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] adr, input logic [22:0] dat);
    @(negedge wb_clk_i);
    cfg_wr_i  = 1'b1;
    cfg_adr_i = adr;
    cfg_dat_i = dat;
    @(negedge wb_clk_i);
    cfg_wr_i  = 1'b0;
  endtask

  task automatic start_seq(input logic [5:0] len);
    @(negedge wb_clk_i);
    len_i   = len;
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge wb_clk_i);
      if (done_o) seen = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      @(negedge wb_clk_i);
      if (!busy_o) idle = 1'b1;
    end
    check_eq({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  task automatic check_log(input string tag, input int base);
    check_eq({tag, "_nwr"}, 32'(log_adr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_adr.size()) begin
        check_eq($sformatf("%s_adr%0d", tag, i), 32'(log_adr[base + i]), 32'(exp_adr[i]));
        check_eq($sformatf("%s_dat%0d", tag, i), log_dat[base + i], exp_dat[i]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          base;
    int          cyc_cnt;
    logic [9:0]  stb_pat, done_pat, busy_pat;

    exp_adr = '{ADR_FIR, ADR_POLE_BASE, 7'h1C, ADR_UPDATE};
    exp_dat = '{32'h0001_0, 32'h3_FFFF, 32'h123, 32'h1};

    wb_rst_i  = 1'b1;
    cfg_wr_i  = 1'b0;
    cfg_adr_i = '0;
    cfg_dat_i = '0;
    len_i     = '0;
    start_i   = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_err",  32'(err_o),  32'd0);
    check_eq("rst_cyc",  32'(bus.wbm_cyc_o), 32'd0);
    check_eq("rst_stb",  32'(bus.wbm_stb_o), 32'd0);
    wb_rst_i = 1'b0;

    cfg_write(5'd0, {5'h01, 18'h00010});
    cfg_write(5'd1, {5'h04, 18'h3FFFF});
    cfg_write(5'd2, {5'h07, 18'h00123});

    // Three entries, slave acks in the second cycle of each bus cycle.
    base = log_adr.size();
    start_seq(6'd3);
    wait_done("seq3", 200);
    check_log("seq3", base);
    check_eq("seq3_err", 32'(err_o), 32'd0);

    // Zero-length load only commits.
    base = log_adr.size();
    start_seq(6'd0);
    wait_done("len0", 50);
    check_eq("len0_nwr", 32'(log_adr.size() - base), 32'd1);
    if (log_adr.size() > base) begin
      check_eq("len0_adr", 32'(log_adr[base]), 32'(ADR_UPDATE));
      check_eq("len0_dat", log_dat[base], 32'h1);
    end

    // Zero-wait slave: cycle-exact stb/done/busy profile after start.
    comb_ack = 1'b1;
    @(negedge wb_clk_i);
    len_i   = 6'd3;
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      start_i     = 1'b0;
      stb_pat[i]  = bus.wbm_stb_o;
      done_pat[i] = done_o;
      busy_pat[i] = busy_o;
    end
    comb_ack = 1'b0;
    check_eq("zw_stb",  32'(stb_pat),  32'(10'b00_1010_1010));
    check_eq("zw_done", 32'(done_pat), 32'(10'b01_0000_0000));
    check_eq("zw_busy", 32'(busy_pat), 32'(10'b01_1111_1111));

    // Silent slave: timeout after 255 cycles with cyc high.
    no_ack  = 1'b1;
    base    = log_adr.size();
    cyc_cnt = 0;
    start_seq(6'd1);
    for (int i = 0; i < 400; i++) begin
      @(negedge wb_clk_i);
      if (bus.wbm_cyc_o) cyc_cnt++;
      else if (cyc_cnt > 0) break;
    end
    no_ack = 1'b0;
    check_eq("to_cycles", 32'(cyc_cnt), 32'd255);
    check_eq("to_err",    32'(err_o),   32'd1);
    check_eq("to_busy",   32'(busy_o),  32'd0);
    check_eq("to_nwr",    32'(log_adr.size() - base), 32'd0);

    // err_i together with ack on the second write aborts; restart recovers.
    err_at       = wr_seen + 1;
    ack_with_err = 1'b1;
    base         = log_adr.size();
    start_seq(6'd3);
    wait_idle("abort", 100);
    check_eq("abort_err", 32'(err_o), 32'd1);
    check_eq("abort_nwr", 32'(log_adr.size() - base), 32'd1);
    err_at       = -1;
    ack_with_err = 1'b0;
    base         = log_adr.size();
    start_seq(6'd3);
    check_eq("restart_err_clr", 32'(err_o), 32'd0);
    wait_done("restart", 200);
    check_log("restart", base);

    // Reset in the middle of a bus cycle drops cyc/stb immediately.
    no_ack = 1'b1;
    start_seq(6'd3);
    for (int i = 0; i < 10 && !bus.wbm_cyc_o; i++) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    check_eq("rstmid_cyc",  32'(bus.wbm_cyc_o), 32'd0);
    check_eq("rstmid_stb",  32'(bus.wbm_stb_o), 32'd0);
    check_eq("rstmid_busy", 32'(busy_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    no_ack   = 1'b0;
    base     = log_adr.size();
    start_seq(6'd3);
    wait_done("replay", 200);
    check_log("replay", base);

    // Table write and start while busy are both ignored.
    ack_dly = 3;
    base    = log_adr.size();
    start_seq(6'd3);
    cfg_write(5'd0, {5'd31, 18'h2AAAA});
    start_seq(6'd1);
    wait_done("busy_ign", 300);
    check_log("busy_ign", base);
    ack_dly = 0;
    base    = log_adr.size();
    start_seq(6'd1);
    wait_done("tbl_keep", 100);
    check_eq("tbl_keep_nwr", 32'(log_adr.size() - base), 32'd2);
    if (log_adr.size() > base) begin
      check_eq("tbl_keep_adr", 32'(log_adr[base]), 32'(ADR_FIR));
      check_eq("tbl_keep_dat", log_dat[base], 32'h10);
    end

    check_eq("bus_sel_we", 32'(bad_bus), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/biquad8_coeff_loader.md
BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 Parameter DEPTH, default 32: coefficient table entries; power of 2, at most 32.
REQ-002 Parameter TIMEOUT, default 255: wb_clk_i cycles allowed per bus cycle without a termination.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous assert, active-high.
REQ-006 cfg_wr_i  input  1  table write strobe.
REQ-007 cfg_adr_i  input  $clog2(DEPTH)  table write index.
REQ-008 cfg_dat_i  input  23  table entry {word_adr[4:0], coeff[17:0]}.
REQ-009 len_i  input  $clog2(DEPTH)+1  number of entries to send, 0..DEPTH; sampled on start.
REQ-010 start_i  input  1  single-cycle start pulse.
REQ-011 busy_o  output  1  sequence in progress.
REQ-012 done_o  output  1  one-cycle pulse on successful completion.
REQ-013 err_o  output  1  sticky abort flag, cleared by the next accepted start.
REQ-014 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  WISHBONE master cycle, strobe, write enable.
REQ-015 wbm_adr_o  output  7  byte address to the biquad register space.
REQ-016 wbm_dat_o  output  32  write data.
REQ-017 wbm_sel_o  output  4  byte selects.
REQ-018 wbm_ack_i, wbm_err_i, wbm_rty_i  input  1 each  slave terminations.

Function
REQ-019 Table write: the table SHALL store cfg_dat_i at cfg_adr_i on cfg_wr_i in IDLE only; writes while busy_o=1 SHALL be ignored; read latency SHALL be 1 cycle.
REQ-020 FSM states: IDLE, FETCH, WRITE, UPDATE, DONE; busy_o=1 in every state except IDLE.
REQ-021 IDLE: start_i with len_i>0 SHALL latch len_i, set index=0, clear err_o, and go to FETCH; start_i with len_i=0 SHALL clear err_o and go to UPDATE; start_i while busy_o=1 SHALL be ignored.
REQ-022 FETCH: read table[index], one cycle, then WRITE; cyc/stb SHALL be low in FETCH, giving at least one idle cycle between bus cycles.
REQ-023 WRITE: cyc=stb=we=1, sel=4'hF, adr={word_adr,2'b00}, dat={14'b0,coeff}; all SHALL be held stable until termination.
REQ-024 On ack in WRITE: index SHALL increment; if new index equals the latched length the next state SHALL be UPDATE, otherwise FETCH; cyc/stb SHALL deassert in the cycle after ack.
REQ-025 UPDATE: write adr=7'h00, dat=32'h1, sel=4'hF; on ack the next state SHALL be DONE.
REQ-026 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-027 Abort: err_i, rty_i, or timeout in WRITE or UPDATE SHALL drop cyc/stb the next cycle, set err_o, return to IDLE, and issue no update write.
REQ-028 Timeout counter SHALL clear at each bus-cycle start and abort when it reaches TIMEOUT without ack.
REQ-029 When ack and err_i are asserted in the same cycle, err_i SHALL take priority (abort).
REQ-030 With a zero-wait-state slave, first stb SHALL assert 2 cycles after start_i; each entry SHALL take 2 cycles.

Reset
REQ-031 wb_rst_i SHALL force IDLE asynchronously, with cyc, stb, we, busy_o, done_o and err_o all 0, and index and counter 0.
REQ-032 Reset SHALL NOT clear table contents.
REQ-033 Reset mid-WRITE SHALL drop cyc/stb without waiting for ack.

Structure
REQ-034 Package biquad8_pkg SHALL hold the FSM enum and address constants: ADR_UPDATE=7'h00, ADR_FIR=7'h04, ADR_POLE_BASE=7'h10.
REQ-035 The table SHALL be a single sub-module, biquad8_coeff_table: simple dual-port with synchronous read.

Verification
REQ-036 Load {0x01,0x00010},{0x04,0x3FFFF},{0x07,0x00123}, len=3, start, ack after 2 cycles -> writes 0x04/0x10, 0x10/0x3FFFF, 0x1C/0x123, then 0x00/0x1, then done_o pulse, err_o=0.
REQ-037 len=0, start -> exactly one write (0x00/0x1), then done_o.
REQ-038 Slave never acks -> cyc drops after 255 cycles, err_o=1, no write to 0x00, busy_o=0.
REQ-039 err_i on the 2nd of 3 writes -> abort, err_o=1; a new start clears err_o and completes all 4 writes.
REQ-040 wb_rst_i mid-WRITE -> cyc/stb low in the same cycle; a following start replays the preserved table unchanged.
REQ-041 cfg_wr_i and start_i while busy -> table and sequence unaffected.
